pipe_scroller: RTL
==================

# pipe_scroller

Drives one scrolling obstacle pipe across the playfield and is the requesting end of the random-height interface. It moves the pipe left once per frame tick. When the pipe leaves the screen, it requests a new gap height, latches it, and respawns the pipe at the right edge. It sits between the frame timing logic and the height generator, and feeds the renderer and collision/score logic.

## Interface
- SPAWN_X, 640: x loaded on respawn (pipe centre, pixels).
- PIPE_W, 80: pipe width in pixels; must be even.
- BIRD_X, 160: x column used for pass/score detection.
- MIN_Y, 40: lowest legal gap_y.
- MAX_Y, 400: highest legal gap_y.
- DEFAULT_Y, 200: gap_y used at reset and on request timeout.
- TIMEOUT, 1024: cycles to wait for height_ack before giving up.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  leave IDLE (level or pulse)
- frame_tick  in  1  one-cycle pulse per video frame
- pause  in  1  freeze motion while high
- speed  in  4  pixels moved per frame tick
- height_in  in  9  candidate gap height from the generator
- height_ack  in  1  height_in valid this cycle
- height_req  out  1  request a new height
- pipe_x  out  11  signed two's-complement pipe centre x
- gap_y  out  9  current gap height (clamped)
- pipe_visible  out  1  pipe overlaps the screen region 0..SPAWN_X
- score_pulse  out  1  one-cycle pulse when the pipe passes BIRD_X
- req_timeout  out  1  sticky flag: a request timed out

## Operation
- States: IDLE, REQ, MOVE.
- Reset (async) sets:
  - state IDLE
  - pipe_x = SPAWN_X
  - gap_y = DEFAULT_Y
  - height_req = 0
  - score_pulse = 0
  - req_timeout = 0
  - timeout counter = 0
- IDLE: stays until start=1, then goes to REQ.
- REQ:
  - height_req = 1; counter increments each cycle.
  - If height_ack=1, latch gap_y = clamp(height_in, MIN_Y, MAX_Y), load pipe_x = SPAWN_X, clear the counter, and go to MOVE.
  - Otherwise, when the counter reaches TIMEOUT-1, latch gap_y = DEFAULT_Y, load pipe_x = SPAWN_X, set req_timeout, and go to MOVE.
  - An ack on the same cycle as the timeout wins; req_timeout is not set.
- MOVE: height_req = 0.
  - On frame_tick=1 with pause=0: pipe_x <= pipe_x - speed (11-bit signed arithmetic; speed zero-extended).
  - If that next x satisfies next_x <= -(PIPE_W/2), go to REQ. The pipe is fully off-screen and pipe_x holds the negative value until respawn.
  - frame_tick with pause=1, or with speed=0, leaves pipe_x unchanged and produces no score.
- Score: score_pulse = 1 for exactly one cycle on the update where pipe_x > BIRD_X and next_x <= BIRD_X (signed).
  - A move that both crosses BIRD_X and goes off-screen scores and then enters REQ.
- pipe_visible (combinational from pipe_x): pipe_x + PIPE_W/2 > 0 and pipe_x - PIPE_W/2 < SPAWN_X.
- frame_tick in IDLE or REQ is ignored; no motion is accumulated.
- height_ack outside REQ is ignored.
- req_timeout clears only on reset.
- Reset mid-REQ or mid-MOVE aborts immediately to the reset values. height_req drops asynchronously with reset.

## Timing
- All outputs are registered except pipe_visible.
- IDLE→REQ: height_req rises one cycle after start is sampled.
- Handshake: height_ack is sampled on the rising edge while height_req=1. gap_y and pipe_x update on that edge, and height_req is low the following cycle.
- A same-cycle ack (ack high on the first REQ cycle) is legal, so minimum REQ occupancy is one cycle.
- Move latency: pipe_x reflects a frame_tick one cycle after the tick edge.
- score_pulse coincides with the pipe_x update.
- Off-screen detection to height_req high: one cycle.

## Test plan
- Reset, start=1, height_ack held high with height_in=250:
  - height_req is seen for 1 cycle.
  - gap_y=250 and pipe_x=640 on the next cycle.
  - req_timeout=0.
- height_in=20, then height_in=500 on a later request: gap_y=40, then gap_y=400 (clamped).
- speed=4, no pause, frame_tick every 10 cycles from pipe_x=640:
  - Exactly one score_pulse, on the tick giving pipe_x=160.
  - Tick 170 gives pipe_x=-40; it is off-screen, so height_req goes high the next cycle.
- Never assert height_ack: after 1024 REQ cycles, gap_y=200, pipe_x=640, req_timeout=1, and the state is MOVE.
- pause=1 over 5 ticks, and speed=0 over 5 ticks: pipe_x is unchanged and there is no score_pulse.
- Assert reset while in REQ with height_req=1:
  - height_req=0 immediately, with state IDLE, pipe_x=640 and gap_y=200.
  - An ack arriving during reset is ignored.

Source files
------------

// File: rtl/pipe_scroller.sv
// Scrolls one obstacle pipe leftward per frame tick and respawns it at the right
// edge after fetching a fresh gap height over a req/ack handshake.
module pipe_scroller #(
  parameter int SPAWN_X   = 640,
  parameter int PIPE_W    = 80,
  parameter int BIRD_X    = 160,
  parameter int MIN_Y     = 40,
  parameter int MAX_Y     = 400,
  parameter int DEFAULT_Y = 200,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic [3:0]         speed,
  input  logic [8:0]         height_in,
  input  logic               height_ack,
  output logic               height_req,
  output logic signed [10:0] pipe_x,
  output logic [8:0]         gap_y,
  output logic               pipe_visible,
  output logic               score_pulse,
  output logic               req_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;

  localparam int HALF = PIPE_W / 2;
  localparam int CW   = $clog2(TIMEOUT);

  localparam logic signed [10:0] SPAWN11 = 11'(SPAWN_X);
  localparam logic signed [10:0] BIRD11  = 11'(BIRD_X);
  localparam logic signed [10:0] NHALF11 = 11'(-HALF);
  localparam logic signed [11:0] HALF12  = 12'(HALF);
  localparam logic signed [11:0] SPAWN12 = 12'(SPAWN_X);
  localparam logic [8:0]         MIN9    = 9'(MIN_Y);
  localparam logic [8:0]         MAX9    = 9'(MAX_Y);
  localparam logic [8:0]         DEF9    = 9'(DEFAULT_Y);
  localparam logic [CW-1:0]      LAST    = CW'(TIMEOUT - 1);

  logic [1:0]         state_q, state_d;
  logic signed [10:0] pipe_x_q, pipe_x_d;
  logic [8:0]         gap_y_q, gap_y_d;
  logic               req_q, req_d;
  logic               score_q, score_d;
  logic               tout_q, tout_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic signed [10:0] nx;
  logic signed [11:0] xe;
  logic [8:0]         clamped;
  logic               step;

  always_comb begin
    nx      = pipe_x_q - $signed({7'b0, speed});
    clamped = height_in;
    if (height_in < MIN9) clamped = MIN9;
    else if (height_in > MAX9) clamped = MAX9;
    step     = frame_tick && !pause && (speed != 4'd0);
    state_d  = state_q;
    pipe_x_d = pipe_x_q;
    gap_y_d  = gap_y_q;
    tout_d   = tout_q;
    cnt_d    = cnt_q;
    score_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (height_ack) begin
          gap_y_d  = clamped;
          pipe_x_d = SPAWN11;
          cnt_d    = '0;
          state_d  = S_MOVE;
        end else if (cnt_q == LAST) begin
          gap_y_d  = DEF9;
          pipe_x_d = SPAWN11;
          tout_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        if (step) begin
          pipe_x_d = nx;
          score_d  = (pipe_x_q > BIRD11) && (nx <= BIRD11);
          if (nx <= NHALF11) state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pipe_x_q <= SPAWN11;
      gap_y_q  <= DEF9;
      req_q    <= 1'b0;
      score_q  <= 1'b0;
      tout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pipe_x_q <= pipe_x_d;
      gap_y_q  <= gap_y_d;
      req_q    <= req_d;
      score_q  <= score_d;
      tout_q   <= tout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Widened by one bit so the +/- half-width edges cannot wrap.
  always_comb begin
    xe           = $signed({pipe_x_q[10], pipe_x_q});
    pipe_visible = (xe + HALF12 > 12'sd0) && (xe - HALF12 < SPAWN12);
  end

  assign height_req  = req_q;
  assign pipe_x      = pipe_x_q;
  assign gap_y       = gap_y_q;
  assign score_pulse = score_q;
  assign req_timeout = tout_q;

endmodule
